// File: rtl/pic_param_pkg.sv
// Shared constants and types for the parametrised interrupt controller.
// Register map, CONFIG bit positions, handshake state encoding.
package pic_param_pkg;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_CONFIG  = 2'd1;
    localparam logic [1:0] ADDR_VECBASE = 2'd2;
    localparam logic [1:0] ADDR_EOI     = 2'd3;

    localparam int CFG_LTIM   = 0;
    localparam int CFG_ROTATE = 1;
    localparam int CFG_AEOI   = 2;
    localparam int CFG_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } pic_state_e;

    // The EOI "specific" flag lives in the MSB of the write data.
    function automatic int eoi_spec_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/pic_rotating_resolver.sv
// Combinational priority pick over a request vector; the scan starts
// just after the lowest-priority pointer and wraps around.
module pic_rotating_resolver #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_IRQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);

    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            logic [ID_W-1:0] w_idx;
            w_idx = i_ptr + ID_W'(k) + ID_W'(1);
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_id    = w_idx;
            end
        end
    end

endmodule

// File: rtl/param_interrupt_controller.sv
// 8259A-style interrupt controller with flat register port, fixed or rotating
// priority, normal/automatic EOI and a two-pulse INTA vector handshake.
module param_interrupt_controller
    import pic_param_pkg::*;
#(
    parameter int                 NUM_IRQ    = 8,
    parameter int                 ID_W       = $clog2(NUM_IRQ),
    parameter int                 DATA_W     = 8,
    parameter logic [NUM_IRQ-1:0] RESET_MASK = '1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NUM_IRQ-1:0] i_irq_in,
    input  logic               i_reg_wr,
    input  logic [1:0]         i_reg_addr,
    input  logic [DATA_W-1:0]  i_reg_wdata,
    input  logic               i_inta,
    output logic               o_int,
    output logic [DATA_W-1:0]  o_vec,
    output logic               o_vec_valid,
    output logic [ID_W-1:0]    o_cas,
    output logic               o_cas_en,
    output logic [NUM_IRQ-1:0] o_irr,
    output logic [NUM_IRQ-1:0] o_isr
);

    localparam int EOI_SPEC_BIT = eoi_spec_bit(DATA_W);

    pic_state_e          r_state;
    logic [NUM_IRQ-1:0]  r_mask;
    logic [CFG_W-1:0]    r_cfg;
    logic [DATA_W-1:0]   r_vecbase;
    logic [ID_W-1:0]     r_ptr;
    logic [NUM_IRQ-1:0]  r_prev;
    logic [NUM_IRQ-1:0]  r_irr;
    logic [NUM_IRQ-1:0]  r_isr;
    logic [ID_W-1:0]     r_id;
    logic                r_spur;
    logic                r_int;
    logic [DATA_W-1:0]   r_vec;
    logic                r_vec_valid;
    logic [ID_W-1:0]     r_cas;
    logic                r_cas_en;

    logic                w_req_valid;
    logic [ID_W-1:0]     w_req_id;
    logic                w_isr_valid;
    logic [ID_W-1:0]     w_isr_id;
    logic                w_qual;
    logic                w_eoi_wr;
    logic                w_eoi_spec;
    logic [ID_W-1:0]     w_eoi_tgt;
    logic                w_eoi_hit;
    logic [NUM_IRQ-1:0]  w_isr_post;
    logic                w_ack_block;
    logic                w_ack_valid;
    logic [ID_W-1:0]     w_ack_id;
    logic [NUM_IRQ-1:0]  w_irr_nxt;
    logic [NUM_IRQ-1:0]  w_isr_nxt;
    logic [ID_W-1:0]     w_ptr_nxt;

    // Position in the current priority order, 0 = highest.
    function automatic logic [ID_W-1:0] f_rank(input logic [ID_W-1:0] id,
                                               input logic [ID_W-1:0] ptr);
        return id - ptr - ID_W'(1);
    endfunction

    pic_rotating_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_req_res (
        .i_req   (r_irr & ~r_mask),
        .i_ptr   (r_ptr),
        .o_valid (w_req_valid),
        .o_id    (w_req_id)
    );

    pic_rotating_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
        .i_req   (r_isr),
        .i_ptr   (r_ptr),
        .o_valid (w_isr_valid),
        .o_id    (w_isr_id)
    );

    assign w_qual = w_req_valid &&
                    (!w_isr_valid || (f_rank(w_req_id, r_ptr) < f_rank(w_isr_id, r_ptr)));

    assign w_eoi_wr   = i_reg_wr && (i_reg_addr == ADDR_EOI);
    assign w_eoi_spec = i_reg_wdata[EOI_SPEC_BIT];
    assign w_eoi_tgt  = w_eoi_spec ? i_reg_wdata[ID_W-1:0] : w_isr_id;
    assign w_eoi_hit  = w_eoi_wr && (w_eoi_spec ? r_isr[w_eoi_tgt] : w_isr_valid);

    always_comb begin
        w_isr_post = r_isr;
        if (w_eoi_hit) begin
            w_isr_post[w_eoi_tgt] = 1'b0;
        end
    end

    // An EOI in the same cycle as the first INTA must unblock the winner.
    always_comb begin
        w_ack_block = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_isr_post[i] && (f_rank(ID_W'(i), r_ptr) <= f_rank(w_req_id, r_ptr))) begin
                w_ack_block = 1'b1;
            end
        end
    end

    assign w_ack_valid = w_req_valid && !w_ack_block;
    assign w_ack_id    = w_ack_valid ? w_req_id : ID_W'(NUM_IRQ - 1);

    always_comb begin
        w_irr_nxt = r_cfg[CFG_LTIM] ? i_irq_in : ((r_irr | (i_irq_in & ~r_prev)) & ~r_mask);
        w_isr_nxt = w_isr_post;
        w_ptr_nxt = (w_eoi_hit && r_cfg[CFG_ROTATE]) ? w_eoi_tgt : r_ptr;
        if ((r_state == ST_IDLE) && i_inta && w_ack_valid) begin
            w_isr_nxt[w_req_id] = 1'b1;
            if (!r_cfg[CFG_LTIM]) begin
                w_irr_nxt[w_req_id] = 1'b0;
            end
        end
        if ((r_state == ST_ACK1) && i_inta && r_cfg[CFG_AEOI] && !r_spur) begin
            w_isr_nxt[r_id] = 1'b0;
            if (r_cfg[CFG_ROTATE]) begin
                w_ptr_nxt = r_id;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_mask      <= RESET_MASK;
            r_cfg       <= '0;
            r_vecbase   <= '0;
            r_ptr       <= ID_W'(NUM_IRQ - 1);
            r_prev      <= '0;
            r_irr       <= '0;
            r_isr       <= '0;
            r_id        <= '0;
            r_spur      <= 1'b0;
            r_int       <= 1'b0;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_cas       <= '0;
            r_cas_en    <= 1'b0;
        end else begin
            r_prev      <= i_irq_in;
            r_irr       <= w_irr_nxt;
            r_isr       <= w_isr_nxt;
            r_ptr       <= w_ptr_nxt;
            r_vec_valid <= 1'b0;
            if (i_reg_wr) begin
                case (i_reg_addr)
                    ADDR_MASK:    r_mask    <= i_reg_wdata[NUM_IRQ-1:0];
                    ADDR_CONFIG:  r_cfg     <= i_reg_wdata[CFG_W-1:0];
                    ADDR_VECBASE: r_vecbase <= i_reg_wdata;
                    default:      ;
                endcase
            end
            case (r_state)
                ST_IDLE: begin
                    r_int <= w_qual;
                    if (i_inta) begin
                        r_state  <= ST_ACK1;
                        r_id     <= w_ack_id;
                        r_spur   <= !w_ack_valid;
                        r_cas    <= w_ack_id;
                        r_cas_en <= 1'b1;
                        r_int    <= 1'b0;
                    end
                end
                ST_ACK1: begin
                    r_int <= 1'b0;
                    if (i_inta) begin
                        r_state     <= ST_ACK2;
                        r_vec       <= r_vecbase + DATA_W'(r_id);
                        r_vec_valid <= 1'b1;
                        r_cas_en    <= 1'b0;
                    end
                end
                default: begin
                    r_int   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_int       = r_int;
    assign o_vec       = r_vec;
    assign o_vec_valid = r_vec_valid;
    assign o_cas       = r_cas;
    assign o_cas_en    = r_cas_en;
    assign o_irr       = r_irr;
    assign o_isr       = r_isr;

endmodule

// File: tb/tb_param_interrupt_controller.sv
// Self-checking bench for param_interrupt_controller: directed scenarios plus
// a randomized run, all checked against a cycle-stepped behavioural model.
module tb_param_interrupt_controller;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  irq;
    logic          reg_wr;
    logic [1:0]    reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          inta;
    logic          o_int;
    logic [DW-1:0] o_vec;
    logic          o_vec_valid;
    logic [IW-1:0] o_cas;
    logic          o_cas_en;
    logic [N-1:0]  o_irr;
    logic [N-1:0]  o_isr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    param_interrupt_controller #(.NUM_IRQ(N), .ID_W(IW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_irq_in    (irq),
        .i_reg_wr    (reg_wr),
        .i_reg_addr  (reg_addr),
        .i_reg_wdata (reg_wdata),
        .i_inta      (inta),
        .o_int       (o_int),
        .o_vec       (o_vec),
        .o_vec_valid (o_vec_valid),
        .o_cas       (o_cas),
        .o_cas_en    (o_cas_en),
        .o_irr       (o_irr),
        .o_isr       (o_isr)
    );

    // Reference model state
    logic [N-1:0]  m_irr, m_isr, m_prev, m_mask;
    int            m_ptr, m_phase, m_id;
    bit            m_ltim, m_rot, m_aeoi, m_spur, m_int, m_vv, m_casen;
    logic [DW-1:0] m_vecbase, m_vec;
    logic [IW-1:0] m_cas;

    function automatic int pos(input int idx, input int ptr);
        return (idx - ptr - 1 + 2 * N) % N;
    endfunction

    function automatic int highest(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + 1 + k) % N]) return (ptr + 1 + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_prev = '0; m_mask = '1;
        m_ptr = N - 1; m_phase = 0; m_id = 0;
        m_ltim = 0; m_rot = 0; m_aeoi = 0; m_spur = 0;
        m_int = 0; m_vv = 0; m_casen = 0;
        m_vecbase = '0; m_vec = '0; m_cas = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] isr_post, irr_n, isr_n;
        int ptr_n, req, hi, ackhi, tgt;
        bit eoi_hit;
        eoi_hit = 0;
        tgt = -1;
        if (reg_wr && reg_addr == 2'd3) begin
            if (reg_wdata[DW-1]) begin
                tgt = int'(reg_wdata[IW-1:0]);
                eoi_hit = m_isr[tgt];
            end else begin
                tgt = highest(m_isr, m_ptr);
                eoi_hit = (tgt >= 0);
            end
        end
        isr_post = m_isr;
        ptr_n = m_ptr;
        if (eoi_hit) begin
            isr_post[tgt] = 1'b0;
            if (m_rot) ptr_n = tgt;
        end
        req = highest(m_irr & ~m_mask, m_ptr);
        hi  = highest(m_isr, m_ptr);
        irr_n = m_ltim ? irq : ((m_irr | (irq & ~m_prev)) & ~m_mask);
        isr_n = isr_post;
        m_vv = 0;
        if (m_phase == 0) begin
            m_int = (req >= 0) && (hi < 0 || pos(req, m_ptr) < pos(hi, m_ptr));
            if (inta) begin
                ackhi = highest(isr_post, m_ptr);
                if (req >= 0 && (ackhi < 0 || pos(req, m_ptr) < pos(ackhi, m_ptr))) begin
                    m_id = req; m_spur = 0;
                    isr_n[req] = 1'b1;
                    if (!m_ltim) irr_n[req] = 1'b0;
                end else begin
                    m_id = N - 1; m_spur = 1;
                end
                m_cas = IW'(m_id); m_casen = 1; m_int = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_int = 0;
            if (inta) begin
                m_vec = m_vecbase + DW'(m_id);
                m_vv = 1; m_casen = 0; m_phase = 2;
                if (m_aeoi && !m_spur) begin
                    isr_n[m_id] = 1'b0;
                    if (m_rot) ptr_n = m_id;
                end
            end
        end else begin
            m_int = 0; m_phase = 0;
        end
        if (reg_wr) begin
            case (reg_addr)
                2'd0: m_mask = reg_wdata[N-1:0];
                2'd1: {m_aeoi, m_rot, m_ltim} = reg_wdata[2:0];
                2'd2: m_vecbase = reg_wdata;
                default: ;
            endcase
        end
        m_irr = irr_n; m_isr = isr_n; m_ptr = ptr_n; m_prev = irq;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        reg_wr = 1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 0;
    endtask

    task automatic do_reset();
        reset_n = 0; irq = '0; reg_wr = 0; reg_addr = '0; reg_wdata = '0; inta = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({o_int, o_vec_valid, o_cas_en, o_vec, o_cas, o_irr, o_isr} !== '0) begin
            $display("FAIL reset_outputs: got int=%b vv=%b casen=%b vec=%h cas=%0d irr=%h isr=%h want all zero",
                     o_int, o_vec_valid, o_cas_en, o_vec, o_cas, o_irr, o_isr);
        end else n_pass++;
        irq[1] = 1'b1;
        tick(); tick();
        n_total++;
        if (o_irr !== 8'h00 || o_int !== 1'b0) begin
            $display("FAIL reset_mask: got irr=%h int=%b want irr=00 int=0", o_irr, o_int);
        end else n_pass++;
    endtask

    task automatic test_edge_capture();
        do_reset();
        wr(2'd0, 8'h00);
        wr(2'd2, 8'h20);
        irq[3] = 1'b1;
        tick();
        irq[3] = 1'b0;
        n_total++;
        if (o_irr !== 8'h08 || o_int !== 1'b0) begin
            $display("FAIL edge_irr: got irr=%h int=%b want irr=08 int=0", o_irr, o_int);
        end else n_pass++;
        tick();
        n_total++;
        if (o_int !== 1'b1) $display("FAIL edge_int: got %b want 1", o_int);
        else n_pass++;
        inta = 1; tick(); inta = 0;
        n_total++;
        if (o_cas !== 3'd3 || o_cas_en !== 1'b1 || o_int !== 1'b0 || o_isr !== 8'h08 || o_irr !== 8'h00) begin
            $display("FAIL edge_ack1: got cas=%0d casen=%b int=%b isr=%h irr=%h want 3 1 0 08 00",
                     o_cas, o_cas_en, o_int, o_isr, o_irr);
        end else n_pass++;
        tick();
        inta = 1; tick(); inta = 0;
        n_total++;
        if (o_vec_valid !== 1'b1 || o_vec !== 8'h23 || o_cas_en !== 1'b0) begin
            $display("FAIL edge_vec: got vv=%b vec=%h casen=%b want 1 23 0", o_vec_valid, o_vec, o_cas_en);
        end else n_pass++;
        tick();
        n_total++;
        if (o_vec_valid !== 1'b0 || o_isr !== 8'h08) begin
            $display("FAIL edge_vv_pulse: got vv=%b isr=%h want 0 08", o_vec_valid, o_isr);
        end else n_pass++;
    endtask

    task automatic ack_pair();
        inta = 1; tick(); inta = 0;
        tick();
        inta = 1; tick(); inta = 0;
    endtask

    task automatic test_priority();
        do_reset();
        wr(2'd0, 8'h00);
        wr(2'd2, 8'h40);
        irq = 8'h24;
        tick(); tick();
        irq = 8'h00;
        inta = 1; tick(); inta = 0;
        n_total++;
        if (o_cas !== 3'd2 || o_cas !== m_cas) $display("FAIL prio_first: got %0d want 2", o_cas);
        else n_pass++;
        tick();
        inta = 1; tick(); inta = 0;
        n_total++;
        if (o_vec !== 8'h42 || o_vec !== m_vec) $display("FAIL prio_vec: got %h want 42", o_vec);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (o_int !== 1'b0 || o_irr !== 8'h20) begin
            $display("FAIL prio_blocked: got int=%b irr=%h want 0 20", o_int, o_irr);
        end else n_pass++;
        wr(2'd3, 8'h00);
        tick();
        n_total++;
        if (o_int !== 1'b1 || o_isr !== 8'h00) begin
            $display("FAIL prio_after_eoi: got int=%b isr=%h want 1 00", o_int, o_isr);
        end else n_pass++;
        ack_pair();
        n_total++;
        if (o_cas !== 3'd5 || o_isr !== 8'h20 || o_vec !== 8'h45) begin
            $display("FAIL prio_second: got cas=%0d isr=%h vec=%h want 5 20 45", o_cas, o_isr, o_vec);
        end else n_pass++;
    endtask

    task automatic test_rotation();
        do_reset();
        wr(2'd1, 8'h02);
        wr(2'd0, 8'h00);
        irq[0] = 1'b1;
        tick(); irq[0] = 1'b0;
        tick();
        ack_pair();
        n_total++;
        if (o_cas !== 3'd0 || o_isr !== 8'h01) $display("FAIL rot_first: got cas=%0d isr=%h want 0 01", o_cas, o_isr);
        else n_pass++;
        wr(2'd3, 8'h00);
        n_total++;
        if (m_ptr != 0 || o_isr !== 8'h00) $display("FAIL rot_ptr: got model ptr=%0d isr=%h want 0 00", m_ptr, o_isr);
        else n_pass++;
        irq = 8'h03;
        tick(); irq = 8'h00;
        tick();
        ack_pair();
        n_total++;
        if (o_cas !== 3'd1 || o_cas !== m_cas || o_isr !== 8'h02) begin
            $display("FAIL rot_second: got cas=%0d isr=%h want 1 02", o_cas, o_isr);
        end else n_pass++;
    endtask

    task automatic test_aeoi_level();
        logic [DW-1:0] vb;
        do_reset();
        vb = DW'($urandom);
        wr(2'd1, 8'h05);
        wr(2'd0, 8'h00);
        wr(2'd2, vb);
        irq[6] = 1'b1;
        tick(); tick();
        ack_pair();
        n_total++;
        if (o_vec_valid !== 1'b1 || o_vec !== DW'(vb + 8'd6) || o_isr !== 8'h00 || o_int !== 1'b0) begin
            $display("FAIL aeoi_vec: got vv=%b vec=%h isr=%h int=%b want 1 %h 00 0",
                     o_vec_valid, o_vec, o_isr, o_int, DW'(vb + 8'd6));
        end else n_pass++;
        tick();
        n_total++;
        if (o_int !== 1'b0) $display("FAIL aeoi_int_gap: got %b want 0", o_int);
        else n_pass++;
        tick();
        n_total++;
        if (o_int !== 1'b1 || o_irr !== 8'h40) $display("FAIL aeoi_reassert: got int=%b irr=%h want 1 40", o_int, o_irr);
        else n_pass++;
        irq = '0;
    endtask

    task automatic test_spurious();
        logic [DW-1:0] vb;
        do_reset();
        vb = DW'($urandom);
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h00);
        wr(2'd2, vb);
        irq[4] = 1'b1;
        tick(); tick();
        irq[4] = 1'b0;
        tick();
        inta = 1; tick(); inta = 0;
        n_total++;
        if (o_cas !== 3'd7 || o_isr !== 8'h00) $display("FAIL spur_cas: got cas=%0d isr=%h want 7 00", o_cas, o_isr);
        else n_pass++;
        tick();
        inta = 1; tick(); inta = 0;
        n_total++;
        if (o_vec_valid !== 1'b1 || o_vec !== DW'(vb + 8'd7) || o_isr !== 8'h00) begin
            $display("FAIL spur_vec: got vv=%b vec=%h isr=%h want 1 %h 00", o_vec_valid, o_vec, o_isr, DW'(vb + 8'd7));
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(2'd0, 8'h00);
        irq[2] = 1'b1;
        tick(); irq[2] = 1'b0;
        tick();
        inta = 1; tick(); inta = 0;
        reset_n = 0;
        model_reset();
        #1;
        n_total++;
        if ({o_int, o_vec_valid, o_cas_en, o_vec, o_cas, o_irr, o_isr} !== '0) begin
            $display("FAIL midreset_outputs: got int=%b vv=%b casen=%b vec=%h cas=%0d irr=%h isr=%h want all zero",
                     o_int, o_vec_valid, o_cas_en, o_vec, o_cas, o_irr, o_isr);
        end else n_pass++;
        @(posedge clk); #1;
        reset_n = 1;
        inta = 1; tick(); inta = 0;
        n_total++;
        if (o_vec_valid !== 1'b0 || o_cas_en !== 1'b1 || o_cas !== 3'd7) begin
            $display("FAIL midreset_novv: got vv=%b casen=%b cas=%0d want 0 1 7", o_vec_valid, o_cas_en, o_cas);
        end else n_pass++;
        irq[5] = 1'b1;
        tick(); tick();
        n_total++;
        if (o_irr !== 8'h00) $display("FAIL midreset_mask: got irr=%h want 00", o_irr);
        else n_pass++;
        irq = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) irq = irq ^ N'($urandom & $urandom);
            inta = ($urandom_range(0, 3) == 0);
            reg_wr = ($urandom_range(0, 5) == 0);
            reg_addr = 2'($urandom);
            reg_wdata = DW'($urandom);
            if (reg_addr == 2'd0) reg_wdata = DW'($urandom & $urandom & $urandom);
            tick();
            n_total++;
            if (o_int !== m_int) $display("FAIL rnd_int c=%0d: got %b want %b", c, o_int, m_int);
            else n_pass++;
            n_total++;
            if (o_irr !== m_irr || o_isr !== m_isr) begin
                $display("FAIL rnd_irr_isr c=%0d: got irr=%h isr=%h want irr=%h isr=%h", c, o_irr, o_isr, m_irr, m_isr);
            end else n_pass++;
            n_total++;
            if (o_vec_valid !== m_vv || o_cas_en !== m_casen || o_cas !== m_cas) begin
                $display("FAIL rnd_hs c=%0d: got vv=%b casen=%b cas=%0d want vv=%b casen=%b cas=%0d",
                         c, o_vec_valid, o_cas_en, o_cas, m_vv, m_casen, m_cas);
            end else n_pass++;
            if (m_vv) begin
                n_total++;
                if (o_vec !== m_vec) $display("FAIL rnd_vec c=%0d: got %h want %h", c, o_vec, m_vec);
                else n_pass++;
            end
        end
        reg_wr = 0; inta = 0; irq = '0;
    endtask

    initial begin
        reset_n = 0; irq = '0; reg_wr = 0; reg_addr = '0; reg_wdata = '0; inta = 0;
        model_reset();
        test_reset();
        test_edge_capture();
        test_priority();
        test_rotation();
        test_aeoi_level();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
